ysyx_24090003_ifu: RTL and testbench

Instruction fetch unit for the multicycle NPC core. Holds the architectural PC, issues one word fetch per instruction over a valid/ready request / valid response memory port, and delivers the fetched instruction and its PC to the decode/execute path with a valid/ready handshake. It consumes the next-PC produced by the execute stage (`EXnpc`) to start the following fetch. The core is non-speculative: at most one instruction is in flight.

---
 rtl/ysyx_24090003_pkg.sv | 20 ++
 rtl/ysyx_24090003_ifu.sv | 114 +++++++++++
 tb/tb_ysyx_24090003_ifu.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24090003_pkg.sv
// Shared types and constants for the ysyx_24090003 NPC core: IFU state encoding,
// the default reset PC and the instruction word substituted on a fetch fault.
package ysyx_24090003_pkg;

  typedef enum logic [1:0] {
    REQ      = 2'd0,
    WAIT     = 2'd1,
    OUT      = 2'd2,
    WAIT_NPC = 2'd3
  } ifu_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] FAULT_INST       = 32'h0000_0000;

  // Word-aligned bus address for a PC; the low two bits never reach the bus.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ysyx_24090003_ifu.sv
// Instruction fetch unit for the multicycle NPC core: one word fetch per instruction,
// next PC supplied by execute. Optional macro: YSYX_IFU_MISALIGN_CHECK_EN.
module ysyx_24090003_ifu
  import ysyx_24090003_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [31:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  input  logic        ifu_rsp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        ex_npc_valid,
  input  logic [31:0] ex_npc
);

  ifu_state_t  state_q;
  logic [31:0] pc_q;
  logic        reqValid_q;
  logic [31:0] reqAddr_q;
  logic        instValid_q;
  logic [31:0] inst_q;
  logic [31:0] instPc_q;
  logic        instFault_q;

  logic [31:0] reqAddr_d;
  logic        npcIssue_d;

  always_comb begin
    reqAddr_d  = alignWord(ex_npc);
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
    npcIssue_d = (ex_npc[1:0] == 2'b00);
`else
    npcIssue_d = 1'b1;
`endif
  end

  // Every output is a register, so no input ever reaches an output in the same cycle.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      reqValid_q  <= 1'b0;
      reqAddr_q   <= RESET_PC;
      instValid_q <= 1'b0;
      inst_q      <= '0;
      instPc_q    <= '0;
      instFault_q <= 1'b0;
    end else begin
      case (state_q)
        REQ: begin
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
          if (pc_q[1:0] != 2'b00) begin
            reqValid_q  <= 1'b0;
            state_q     <= OUT;
            instValid_q <= 1'b1;
            inst_q      <= FAULT_INST;
            instPc_q    <= pc_q;
            instFault_q <= 1'b1;
          end else
`endif
          if (reqValid_q && ifu_req_ready) begin
            reqValid_q <= 1'b0;
            state_q    <= WAIT;
          end else begin
            reqValid_q <= 1'b1;
            reqAddr_q  <= alignWord(pc_q);
          end
        end
        WAIT: begin
          if (ifu_rsp_valid) begin
            state_q     <= OUT;
            instValid_q <= 1'b1;
            inst_q      <= ifu_rsp_err ? FAULT_INST : ifu_rsp_data;
            instPc_q    <= pc_q;
            instFault_q <= ifu_rsp_err;
          end
        end
        OUT: begin
          if (instValid_q && inst_ready) begin
            instValid_q <= 1'b0;
            state_q     <= WAIT_NPC;
          end
        end
        WAIT_NPC: begin
          // Raise the request together with the PC update to save a cycle per instruction.
          if (ex_npc_valid) begin
            pc_q       <= ex_npc;
            state_q    <= REQ;
            reqValid_q <= npcIssue_d;
            reqAddr_q  <= reqAddr_d;
          end
        end
        default: state_q <= REQ;
      endcase
    end
  end

  assign ifu_req_valid = reqValid_q;
  assign ifu_req_addr  = reqAddr_q;
  assign inst_valid    = instValid_q;
  assign inst          = inst_q;
  assign inst_pc       = instPc_q;
  assign inst_fault    = instFault_q;

endmodule

// File: tb/tb_ysyx_24090003_ifu.sv
// Self-checking bench for ysyx_24090003_ifu: acts as instruction memory and execute
// stage, comparing against a transaction-level model of the fetch loop.
module tb_ysyx_24090003_ifu;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        ex_npc_valid;
  logic [31:0] ex_npc;

  int checks = 0;
  int passes = 0;
  int hsCount = 0;

  ysyx_24090003_ifu dut (
    .cpu_clk      (cpu_clk),
    .cpu_rst_n    (cpu_rst_n),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr (ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data (ifu_rsp_data),
    .ifu_rsp_err  (ifu_rsp_err),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_fault   (inst_fault),
    .ex_npc_valid (ex_npc_valid),
    .ex_npc       (ex_npc)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Independent count of request handshakes seen on the memory port.
  always @(posedge cpu_clk) begin
    if (cpu_rst_n && ifu_req_valid && ifu_req_ready) hsCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    else
      passes++;
  endtask

  function automatic logic [31:0] wordAddr(input logic [31:0] pc);
    return pc - (pc % 4);
  endfunction

  function automatic bit faultsOnAlign(input logic [31:0] pc);
`ifdef YSYX_IFU_MISALIGN_CHECK_EN
    return (pc % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_reqValid"}, 32'(ifu_req_valid), 32'd0);
    checkOutput({tag, "_reqAddr"}, ifu_req_addr, 32'h8000_0000);
    checkOutput({tag, "_instValid"}, 32'(inst_valid), 32'd0);
    checkOutput({tag, "_inst"}, inst, 32'd0);
    checkOutput({tag, "_instPc"}, inst_pc, 32'd0);
    checkOutput({tag, "_fault"}, 32'(inst_fault), 32'd0);
  endtask

  // Report the next PC after idle cycles in which no request may appear.
  task automatic issueNpc(input logic [31:0] npc, input int idle);
    repeat (idle) begin
      tick();
      checkOutput("noReqBeforeNpc", 32'(ifu_req_valid), 32'd0);
    end
    ex_npc_valid = 1'b1;
    ex_npc       = npc;
    tick();
    ex_npc_valid = 1'b0;
    ex_npc       = $urandom;
    if (faultsOnAlign(npc)) begin
      checkOutput("misalignNoReq", 32'(ifu_req_valid), 32'd0);
    end else begin
      checkOutput("reqAfterNpc", 32'(ifu_req_valid), 32'd1);
      checkOutput("reqAddrAfterNpc", ifu_req_addr, wordAddr(npc));
    end
  endtask

  // Carry one instruction at PC pc through fetch and delivery.
  task automatic applyStimulus(input logic [31:0] pc, input int reqHold, input int rspDelay,
                               input logic [31:0] data, input logic err, input int outHold);
    logic [31:0] expInst;
    logic        expFault;
    int          hs0;
    int          n;
    if (faultsOnAlign(pc)) begin
      checkOutput("misalignNoReq2", 32'(ifu_req_valid), 32'd0);
      tick();
      expInst  = 32'h0;
      expFault = 1'b1;
    end else begin
      n = 0;
      while (!ifu_req_valid && n < 8) begin
        tick();
        n++;
      end
      checkOutput("reqSeen", 32'(ifu_req_valid), 32'd1);
      checkOutput("reqAddr", ifu_req_addr, wordAddr(pc));
      hs0 = hsCount;
      ifu_req_ready = 1'b0;
      repeat (reqHold) begin
        tick();
        checkOutput("reqHeld", 32'(ifu_req_valid), 32'd1);
        checkOutput("reqAddrStable", ifu_req_addr, wordAddr(pc));
      end
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      checkOutput("oneHandshake", 32'(hsCount - hs0), 32'd1);
      checkOutput("reqDropped", 32'(ifu_req_valid), 32'd0);
      repeat (rspDelay) begin
        tick();
        checkOutput("noInstBeforeRsp", 32'(inst_valid), 32'd0);
      end
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = data;
      ifu_rsp_err   = err;
      tick();
      ifu_rsp_valid = 1'b0;
      ifu_rsp_data  = $urandom;
      ifu_rsp_err   = 1'b0;
      expInst  = err ? 32'h0 : data;
      expFault = err;
    end
    checkOutput("instValid", 32'(inst_valid), 32'd1);
    checkOutput("inst", inst, expInst);
    checkOutput("instPc", inst_pc, pc);
    checkOutput("instFault", 32'(inst_fault), 32'(expFault));
    repeat (outHold) begin
      tick();
      checkOutput("instHeldValid", 32'(inst_valid), 32'd1);
      checkOutput("instStable", inst, expInst);
      checkOutput("instPcStable", inst_pc, pc);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checkOutput("instDropped", 32'(inst_valid), 32'd0);
    checkOutput("instKept", inst, expInst);
    checkOutput("instPcKept", inst_pc, pc);
  endtask

  initial begin
    logic [31:0] npc;
    int          hs0;
    cpu_rst_n     = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = '0;
    ifu_rsp_err   = 1'b0;
    inst_ready    = 1'b0;
    ex_npc_valid  = 1'b0;
    ex_npc        = '0;

    repeat (2) tick();
    checkResetOutputs("reset");
    cpu_rst_n = 1'b1;
    tick();
    checkOutput("reqAfterReset", 32'(ifu_req_valid), 32'd1);
    checkOutput("reqAddrAfterReset", ifu_req_addr, 32'h8000_0000);

    applyStimulus(32'h8000_0000, 0, 0, 32'h0000_0413, 1'b0, 0);

    issueNpc(32'h8000_0004, 2);
    applyStimulus(32'h8000_0004, 3, 0, 32'h0040_0093, 1'b0, 4);

    issueNpc(32'h8000_0010, 3);
    applyStimulus(32'h8000_0010, 0, 1, 32'h0010_0073, 1'b0, 0);

    issueNpc(32'h8000_0014, 0);
    applyStimulus(32'h8000_0014, 1, 0, 32'hdead_beef, 1'b1, 1);

    issueNpc(32'h8000_0002, 1);
    applyStimulus(32'h8000_0002, 0, 0, 32'h1234_5678, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      npc = {$urandom} & 32'h0000_FFFF;
      npc = npc | 32'h8000_0000;
      if ($urandom_range(0, 3) != 0) npc = wordAddr(npc);
      issueNpc(npc, $urandom_range(0, 2));
      applyStimulus(npc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Reset while a fetch is outstanding, then a stale response arrives.
    issueNpc(32'h8000_0100, 0);
    hs0 = hsCount;
    ifu_req_ready = 1'b1;
    tick();
    ifu_req_ready = 1'b0;
    checkOutput("midHandshake", 32'(hsCount - hs0), 32'd1);
    cpu_rst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    tick();
    cpu_rst_n = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_data  = 32'hbad0_bad0;
    tick();
    ifu_rsp_valid = 1'b0;
    checkOutput("staleIgnored", 32'(inst_valid), 32'd0);
    checkOutput("reqAfterMidReset", 32'(ifu_req_valid), 32'd1);
    checkOutput("reqAddrAfterMidReset", ifu_req_addr, 32'h8000_0000);
    applyStimulus(32'h8000_0000, 0, 0, 32'h0000_0513, 1'b0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
